sal_addr_decoder_mb: RTL

Parametrised multi-bank successor to the single-bank request decoder. It takes AXI read and write address channels and snoops W-channel last beats, so a write is only issued once all of its data is present. It arbitrates reads and writes round-robin, decodes bank, row and column from the address, and drives a registered request to the one target bank controller out of BK_CNT. It sits between the AXI slave front-end and the per-bank controllers.

---
 rtl/sal_addr_decoder_mb.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sal_addr_decoder_mb.sv
`default_nettype none
// ============================================================================
//  Module      : sal_addr_decoder_mb
//  Description : Multi-bank AXI address decoder. Accepts AR/AW requests,
//                holds a write back until all of its data beats are present,
//                alternates reads and writes round-robin, and issues one
//                registered request to the addressed bank controller.
//  Revision    : 1.0 - initial multi-bank release
// ============================================================================
module sal_addr_decoder_mb #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 4,
    parameter int BK_CNT     = 4,
    parameter int OFS_WIDTH  = 3,
    parameter int CA_WIDTH   = 10,
    parameter int RA_WIDTH   = 13,
    parameter int WCNT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // AXI read address channel
    input  logic                  ar_valid,
    output logic                  ar_ready,
    input  logic [ID_WIDTH-1:0]   ar_id,
    input  logic [ADDR_WIDTH-1:0] ar_addr,
    input  logic [LEN_WIDTH-1:0]  ar_len,
    // AXI write address channel
    input  logic                  aw_valid,
    output logic                  aw_ready,
    input  logic [ID_WIDTH-1:0]   aw_id,
    input  logic [ADDR_WIDTH-1:0] aw_addr,
    input  logic [LEN_WIDTH-1:0]  aw_len,
    // W channel snoop
    input  logic                  w_valid,
    input  logic                  w_ready,
    input  logic                  w_last,
    output logic                  w_hold,
    // Bank request interface
    output logic [BK_CNT-1:0]     bk_valid,
    input  logic [BK_CNT-1:0]     bk_ready,
    output logic [ID_WIDTH-1:0]   bk_id,
    output logic [RA_WIDTH-1:0]   bk_ra,
    output logic [CA_WIDTH-1:0]   bk_ca,
    output logic [LEN_WIDTH-1:0]  bk_len,
    output logic                  bk_wr,
    output logic [WCNT_WIDTH-1:0] wcnt
);

    localparam int c_ba_w   = $clog2(BK_CNT);
    localparam int c_ca_lsb = OFS_WIDTH;
    localparam int c_ba_lsb = OFS_WIDTH + CA_WIDTH;
    localparam int c_ra_lsb = OFS_WIDTH + CA_WIDTH + c_ba_w;
    localparam logic [WCNT_WIDTH-1:0] c_wcnt_max = '1;
    localparam logic [BK_CNT-1:0]     c_bk_one   = {{(BK_CNT-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_prio_wr;
    logic [WCNT_WIDTH-1:0] r_wcnt;
    logic [BK_CNT-1:0]     r_bk_valid;
    logic [ID_WIDTH-1:0]   r_bk_id;
    logic [RA_WIDTH-1:0]   r_bk_ra;
    logic [CA_WIDTH-1:0]   r_bk_ca;
    logic [LEN_WIDTH-1:0]  r_bk_len;
    logic                  r_bk_wr;

    logic                  w_wl_hs;
    logic                  w_aw_hs;
    logic                  w_rd_el;
    logic                  w_wr_el;
    logic                  w_drain;
    logic                  w_can_load;
    logic                  w_grant_rd;
    logic                  w_grant_wr;
    logic                  w_load;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [c_ba_w-1:0]     w_sel_ba;
    logic                  w_unused;

    // Bits above the row field play no part in the decode
    assign w_unused = ^{ar_addr, aw_addr};

    assign w_wl_hs = w_valid & w_ready & w_last;
    assign w_aw_hs = aw_valid & aw_ready;

    // A write is only eligible once at least one complete data burst is held
    assign w_rd_el = ar_valid;
    assign w_wr_el = aw_valid & (r_wcnt != '0);

    // Held request leaves when its own bank accepts; other banks are ignored
    assign w_drain    = (r_state == S_FULL) & (|(r_bk_valid & bk_ready));
    assign w_can_load = (r_state == S_EMPTY) | w_drain;

    assign w_grant_wr = w_wr_el & (~w_rd_el | r_prio_wr);
    assign w_grant_rd = w_rd_el & (~w_wr_el | ~r_prio_wr);

    assign ar_ready = w_can_load & w_grant_rd;
    assign aw_ready = w_can_load & w_grant_wr;
    assign w_load   = ar_ready | aw_ready;

    assign w_sel_addr = aw_ready ? aw_addr : ar_addr;
    assign w_sel_ba   = w_sel_addr[c_ba_lsb +: c_ba_w];

    assign w_hold   = (r_wcnt == c_wcnt_max);
    assign wcnt     = r_wcnt;
    assign bk_valid = r_bk_valid;
    assign bk_id    = r_bk_id;
    assign bk_ra    = r_bk_ra;
    assign bk_ca    = r_bk_ca;
    assign bk_len   = r_bk_len;
    assign bk_wr    = r_bk_wr;

    // Count complete write-data bursts not yet matched by an issued AW
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt <= '0;
        end else if (w_wl_hs && !w_aw_hs) begin
            if (r_wcnt != c_wcnt_max) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
        end else if (w_aw_hs && !w_wl_hs) begin
            if (r_wcnt != '0) begin
                r_wcnt <= r_wcnt - 1'b1;
            end
        end
    end

    // Output register: load on grant (possibly while draining), else drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_prio_wr  <= 1'b0;
            r_bk_valid <= '0;
            r_bk_id    <= '0;
            r_bk_ra    <= '0;
            r_bk_ca    <= '0;
            r_bk_len   <= '0;
            r_bk_wr    <= 1'b0;
        end else if (w_load) begin
            r_state    <= S_FULL;
            r_prio_wr  <= ~w_grant_wr;
            r_bk_valid <= c_bk_one << w_sel_ba;
            r_bk_id    <= aw_ready ? aw_id  : ar_id;
            r_bk_len   <= aw_ready ? aw_len : ar_len;
            r_bk_ra    <= w_sel_addr[c_ra_lsb +: RA_WIDTH];
            r_bk_ca    <= w_sel_addr[c_ca_lsb +: CA_WIDTH];
            r_bk_wr    <= aw_ready;
        end else if (w_drain) begin
            r_state    <= S_EMPTY;
            r_bk_valid <= '0;
        end
    end

`ifndef SYNTHESIS
    // Completing a W burst while the counter is full loses a write
    a_no_wcnt_overflow : assert property (
        @(posedge clk) disable iff (!rst_n) !(w_wl_hs && w_hold)
    );
`endif

endmodule
`default_nettype wire
